// File: rtl/reg_scan_reader.sv
// Register-file read-side scanner: walks a register range (or reads one register)
// and streams each (index, value) pair to a display/dump consumer over valid/ready.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | waiting for Start; Ra parked at 0 after reset
// ADDR    | Ra driven, busA settling; value captured on the closing edge
// PRESENT | pair held on OutIdx/OutData until the consumer accepts it
// FINISH  | one-cycle Done pulse, then back to IDLE
module reg_scan_reader #(
    parameter int LO_REG = 0,
    parameter int HI_REG = 31
) (
    input  logic        Clk,
    input  logic        Rst_n,
    input  logic        Start,
    input  logic        SingleReg,
    input  logic [4:0]  RegSel,
    output logic [4:0]  Ra,
    input  logic [31:0] busA,
    output logic        OutValid,
    input  logic        OutReady,
    output logic [4:0]  OutIdx,
    output logic [31:0] OutData,
    output logic        Busy,
    output logic        Done
);

    localparam logic [4:0] LO_IDX = 5'(LO_REG);
    localparam logic [4:0] HI_IDX = 5'(HI_REG);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ADDR    = 2'd1,
        PRESENT = 2'd2,
        FINISH  = 2'd3
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [4:0]  end_idx;
    logic [4:0]  end_idx_nxt;
    logic [4:0]  ra_nxt;
    logic        out_valid_nxt;
    logic [4:0]  out_idx_nxt;
    logic [31:0] out_data_nxt;

    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            state    <= IDLE;
            end_idx  <= 5'd0;
            Ra       <= 5'd0;
            OutValid <= 1'b0;
            OutIdx   <= 5'd0;
            OutData  <= 32'd0;
        end else begin
            state    <= state_nxt;
            end_idx  <= end_idx_nxt;
            Ra       <= ra_nxt;
            OutValid <= out_valid_nxt;
            OutIdx   <= out_idx_nxt;
            OutData  <= out_data_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        end_idx_nxt   = end_idx;
        ra_nxt        = Ra;
        out_valid_nxt = OutValid;
        out_idx_nxt   = OutIdx;
        out_data_nxt  = OutData;

        case (state)
            IDLE: begin
                if (Start) begin
                    // Single mode is just a scan whose first and last index coincide.
                    ra_nxt      = SingleReg ? RegSel : LO_IDX;
                    end_idx_nxt = SingleReg ? RegSel : HI_IDX;
                    state_nxt   = ADDR;
                end
            end
            ADDR: begin
                out_data_nxt  = busA;
                out_idx_nxt   = Ra;
                out_valid_nxt = 1'b1;
                state_nxt     = PRESENT;
            end
            PRESENT: begin
                if (OutValid && OutReady) begin
                    out_valid_nxt = 1'b0;
                    if (OutIdx == end_idx) begin
                        state_nxt = FINISH;
                    end else begin
                        ra_nxt    = Ra + 5'd1;
                        state_nxt = ADDR;
                    end
                end
            end
            FINISH: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    assign Busy = (state != IDLE);
    assign Done = (state == FINISH);

endmodule

// File: tb/tb_reg_scan_reader.sv
// Self-checking bench for reg_scan_reader: a behavioural register file plus an
// expected-pair queue built from the scan rules, with directed and random operations.
`timescale 1ns/1ps
module tb_reg_scan_reader;

    localparam int LO = 0;
    localparam int HI = 31;

    logic        Clk = 1'b0;
    logic        Rst_n;
    logic        Start;
    logic        SingleReg;
    logic [4:0]  RegSel;
    logic [4:0]  Ra;
    logic [31:0] busA;
    logic        OutValid;
    logic        OutReady;
    logic [4:0]  OutIdx;
    logic [31:0] OutData;
    logic        Busy;
    logic        Done;

    logic [31:0] regs [32];
    int n_checks = 0;
    int n_fail   = 0;

    always #5 Clk = ~Clk;

    assign busA = (Ra == 5'd0) ? 32'd0 : regs[Ra];

    reg_scan_reader #(.LO_REG(LO), .HI_REG(HI)) dut (
        .Clk(Clk), .Rst_n(Rst_n), .Start(Start), .SingleReg(SingleReg),
        .RegSel(RegSel), .Ra(Ra), .busA(busA), .OutValid(OutValid),
        .OutReady(OutReady), .OutIdx(OutIdx), .OutData(OutData),
        .Busy(Busy), .Done(Done)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] ref_val(input int idx);
        return (idx == 0) ? 32'd0 : regs[idx];
    endfunction

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_ra"},    32'(Ra), 32'd0);
        check({tag, "_valid"}, 32'(OutValid), 32'd0);
        check({tag, "_idx"},   32'(OutIdx), 32'd0);
        check({tag, "_data"},  OutData, 32'd0);
        check({tag, "_busy"},  32'(Busy), 32'd0);
        check({tag, "_done"},  32'(Done), 32'd0);
    endtask

    // One complete operation: expected pairs come from the mode rules, data from the
    // register model. Ready is random with probability ready_pct; at 100 the fixed
    // two-cycle cadence is also checked. A stray Start is pulsed at cycle stray_at.
    task automatic run_op(input bit single, input logic [4:0] sel, input int ready_pct,
                          input int stray_at);
        int q[$];
        int t;
        int k;
        int last_hs;
        int exp_idx;
        bit pv;
        bit pr;
        bit first_seen;
        bit done_seen;
        logic [4:0]  pidx;
        logic [31:0] pdata;

        if (single) q.push_back(int'(sel));
        else for (int i = LO; i <= HI; i++) q.push_back(i);

        Start = 1'b1; SingleReg = single; RegSel = sel; OutReady = 1'b0;
        step();
        Start = 1'b0; SingleReg = 1'($urandom); RegSel = 5'($urandom);

        t = 0; k = 0; last_hs = -10; pv = 0; pr = 0; first_seen = 0; done_seen = 0;
        pidx = '0; pdata = '0;
        while (t < 400 && !done_seen) begin
            if (t == stray_at) begin
                Start = 1'b1; SingleReg = 1'b1; RegSel = 5'd7;
            end else begin
                Start = 1'b0;
            end
            if (Done) begin
                Start = 1'b0;
                check("done_pending", q.size(), 32'd0);
                check("done_latency", t, last_hs + 1);
                check("busy_in_done", 32'(Busy), 32'd1);
                check("valid_in_done", 32'(OutValid), 32'd0);
                done_seen = 1;
            end else begin
                check("busy", 32'(Busy), 32'd1);
                if (pv && !pr) begin
                    check("hold_valid", 32'(OutValid), 32'd1);
                    check("hold_idx", 32'(OutIdx), 32'(pidx));
                    check("hold_data", OutData, pdata);
                end
                if (OutValid && !first_seen) begin
                    first_seen = 1;
                    check("first_valid_latency", t, 32'd1);
                end
                OutReady = ($urandom_range(0, 99) < ready_pct);
                if (OutValid && q.size() == 0) check("extra_pair", 32'd1, 32'd0);
                if (OutValid && q.size() > 0) begin
                    check("ra_hold", 32'(Ra), q[0]);
                    if (OutReady) begin
                        exp_idx = q.pop_front();
                        check("pair_idx", 32'(OutIdx), exp_idx);
                        check("pair_data", OutData, ref_val(exp_idx));
                        if (ready_pct >= 100) check("pair_cadence", t, 1 + 2 * k);
                        k++;
                        last_hs = t;
                    end
                end
                pv = OutValid; pr = OutReady; pidx = OutIdx; pdata = OutData;
            end
            step();
            t++;
        end
        OutReady = 1'b0;
        if (!done_seen) check("op_timeout", 32'd0, 32'd1);
        check("busy_after_done", 32'(Busy), 32'd0);
        check("done_single_pulse", 32'(Done), 32'd0);
    endtask

    initial begin
        int guard;
        Rst_n = 1'b0; Start = 1'b0; SingleReg = 1'b0; RegSel = 5'd0; OutReady = 1'b0;
        for (int k = 0; k < 32; k++) regs[k] = 32'(k) * 32'h1111_1111;
        regs[0] = 32'd0;

        // reset then idle
        step(); step();
        Rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            check_idle("idle");
            step();
        end

        // full scan without backpressure, then one with a stray Start, then a
        // single read launched in the cycle right after Done
        run_op(1'b0, 5'd0, 100, -1);
        run_op(1'b0, 5'd0, 100, 20);
        run_op(1'b1, 5'd4, 100, -1);

        // backpressure on a single read
        regs[5] = 32'hDEAD_BEEF;
        Start = 1'b1; SingleReg = 1'b1; RegSel = 5'd5; OutReady = 1'b0;
        step();
        Start = 1'b0;
        step();
        for (int i = 0; i < 10; i++) begin
            check("bp_valid", 32'(OutValid), 32'd1);
            check("bp_idx", 32'(OutIdx), 32'd5);
            check("bp_data", OutData, 32'hDEAD_BEEF);
            check("bp_ra", 32'(Ra), 32'd5);
            step();
        end
        OutReady = 1'b1;
        step();
        OutReady = 1'b0;
        check("bp_valid_drop", 32'(OutValid), 32'd0);
        check("bp_done", 32'(Done), 32'd1);
        step();
        check("bp_idle_busy", 32'(Busy), 32'd0);

        // write after capture is invisible
        regs[3] = 32'h1;
        Start = 1'b1; SingleReg = 1'b1; RegSel = 5'd3;
        step();
        Start = 1'b0;
        step();
        check("wr_capt_data", OutData, 32'h1);
        regs[3] = 32'h2;
        step();
        check("wr_after_data0", OutData, 32'h1);
        step();
        check("wr_after_data1", OutData, 32'h1);
        OutReady = 1'b1;
        step();
        OutReady = 1'b0;
        check("wr_done", 32'(Done), 32'd1);
        step();

        // write during the address cycle is returned
        regs[9] = 32'hAAAA_0009;
        Start = 1'b1; SingleReg = 1'b1; RegSel = 5'd9;
        step();
        Start = 1'b0;
        regs[9] = 32'h5555_0009;
        step();
        check("wr_addr_data", OutData, 32'h5555_0009);
        OutReady = 1'b1;
        step();
        OutReady = 1'b0;
        step();

        // reset mid-scan while presenting index 12
        Start = 1'b1; SingleReg = 1'b0; OutReady = 1'b1;
        step();
        Start = 1'b0;
        guard = 0;
        while (!(OutValid && OutIdx == 5'd12) && guard < 200) begin
            step();
            guard++;
        end
        check("reach_idx12", 32'(OutIdx), 32'd12);
        Rst_n = 1'b0;
        step();
        Rst_n = 1'b1; OutReady = 1'b0;
        check_idle("midrst");
        step();
        check_idle("midrst_after");
        run_op(1'b0, 5'd0, 100, -1);

        // random operations against the model
        for (int n = 0; n < 10; n++) begin
            bit sm;
            for (int k = 1; k < 32; k++) regs[k] = $urandom;
            sm = 1'($urandom);
            run_op(sm, 5'($urandom), int'($urandom_range(30, 100)),
                   sm ? -1 : int'($urandom_range(2, 40)));
            for (int g = 0; g < int'($urandom_range(0, 3)); g++) step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
